// File: rtl/oped_wci_pkg.sv
// Shared types and constants for the OPED WCI-to-AXI4-Lite master.
package oped_wci_pkg;

  localparam logic [1:0] WCI_OK      = 2'd0;
  localparam logic [1:0] WCI_SLVERR  = 2'd1;
  localparam logic [1:0] WCI_DECERR  = 2'd2;
  localparam logic [1:0] WCI_TIMEOUT = 2'd3;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RRESP,
    ST_RESP
  } wci_state_e;

  // AXI OKAY/EXOKAY are success; SLVERR and DECERR map onto the WCI codes of the same name.
  function automatic logic [1:0] axi_resp_to_code(input logic [1:0] resp);
    case (resp)
      2'b10:   axi_resp_to_code = WCI_SLVERR;
      2'b11:   axi_resp_to_code = WCI_DECERR;
      default: axi_resp_to_code = WCI_OK;
    endcase
  endfunction

endpackage

// File: rtl/oped_wci_timer.sv
// Loadable down-counter; expired_c flags the last enabled cycle of a countdown.
module oped_wci_timer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_c = en && (cnt_q == '0);

endmodule

// File: rtl/oped_wci_axil_master.sv
// WCI control-plane requests to AXI4-Lite, one transaction at a time, over NUM_WORKERS address windows.
// Optional handshake timeout with per-worker fault isolation: define OPED_WCI_TIMEOUT_EN.
module oped_wci_axil_master
  import oped_wci_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_WORKERS = 16,
  parameter int unsigned       WIN_LOG2    = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       TIMEOUT_CYC = 4096,
  localparam int unsigned      WK_W        = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1,
  localparam int unsigned      STRB_W      = DATA_W / 8
) (
  input  logic                   oped_clk125,
  input  logic                   oped_reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [WK_W-1:0]        req_worker,
  input  logic [WIN_LOG2-1:0]    req_offset,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [STRB_W-1:0]      req_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [1:0]             rsp_code,
  input  logic [NUM_WORKERS-1:0] fault_clr,
  output logic [NUM_WORKERS-1:0] fault,
  output logic                   busy,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [ADDR_W-1:0]      m_awaddr,
  output logic [2:0]             m_awprot,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  output logic [DATA_W-1:0]      m_wdata,
  output logic [STRB_W-1:0]      m_wstrb,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  input  logic [1:0]             m_bresp,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [ADDR_W-1:0]      m_araddr,
  output logic [2:0]             m_arprot,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic [1:0]             m_rresp
);

  wci_state_e          state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_code_q, rsp_code_d;
  logic                busy_q, busy_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [WK_W-1:0]     wk_q, wk_d;
  logic                tmr_load_c;
  logic                tmr_expired_c;
  logic                faulted_c;
  logic                abort_c;

`ifdef OPED_WCI_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [NUM_WORKERS-1:0] fault_q;
  logic                   tmr_en_c;

  assign tmr_en_c = (state_q == ST_WADDR) || (state_q == ST_WRESP) ||
                    (state_q == ST_RADDR) || (state_q == ST_RRESP);

  // Loaded with TIMEOUT_CYC-1 so expiry lands on the TIMEOUT_CYC-th waiting cycle.
  oped_wci_timer #(
    .CNT_W(TMR_W)
  ) u_timer (
    .clk      (oped_clk125),
    .rst      (oped_reset),
    .load     (tmr_load_c),
    .load_val (TMR_W'(TIMEOUT_CYC - 1)),
    .en       (tmr_en_c),
    .expired_c(tmr_expired_c)
  );

  assign faulted_c = fault_q[req_worker];

  // A timeout on the same cycle as a clear keeps the worker isolated.
  always_ff @(posedge oped_clk125) begin
    if (oped_reset) begin
      fault_q <= '0;
    end else begin
      fault_q <= (fault_q & ~fault_clr) |
                 (abort_c ? (NUM_WORKERS'(1) << wk_q) : '0);
    end
  end

  assign fault = fault_q;
`else
  logic unused_cfg;

  assign tmr_expired_c = 1'b0;
  assign faulted_c     = 1'b0;
  assign fault         = '0;
  assign unused_cfg    = ^{fault_clr, tmr_load_c, abort_c, wk_q, 32'(TIMEOUT_CYC)};
`endif

  // Next-state and next-output decode; every output is a flop loaded from its _d value.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_code_d  = rsp_code_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wk_d        = wk_q;
    tmr_load_c  = 1'b0;
    abort_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          addr_d      = ADDR_W'(64'(BASE_ADDR) + (64'(req_worker) << WIN_LOG2) + 64'(req_offset));
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          wk_d        = req_worker;
          if (32'(req_worker) >= NUM_WORKERS) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_code_d  = WCI_DECERR;
            rsp_data_d  = '0;
          end else if (faulted_c) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_code_d  = WCI_TIMEOUT;
            rsp_data_d  = '0;
          end else if (req_write) begin
            state_d    = ST_WADDR;
            awvalid_d  = 1'b1;
            wvalid_d   = 1'b1;
            tmr_load_c = 1'b1;
          end else begin
            state_d    = ST_RADDR;
            arvalid_d  = 1'b1;
            tmr_load_c = 1'b1;
          end
        end
      end
      ST_WADDR: begin
        awvalid_d = awvalid_q && !m_awready;
        wvalid_d  = wvalid_q && !m_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d    = ST_WRESP;
          bready_d   = 1'b1;
          tmr_load_c = 1'b1;
        end else if (tmr_expired_c) begin
          abort_c = 1'b1;
        end
      end
      ST_WRESP: begin
        if (m_bvalid) begin
          state_d     = ST_RESP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = axi_resp_to_code(m_bresp);
          rsp_data_d  = '0;
        end else if (tmr_expired_c) begin
          abort_c = 1'b1;
        end
      end
      ST_RADDR: begin
        if (m_arready) begin
          state_d    = ST_RRESP;
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          tmr_load_c = 1'b1;
        end else if (tmr_expired_c) begin
          abort_c = 1'b1;
        end
      end
      ST_RRESP: begin
        if (m_rvalid) begin
          state_d     = ST_RESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = axi_resp_to_code(m_rresp);
          rsp_data_d  = (axi_resp_to_code(m_rresp) == WCI_OK) ? m_rdata : '0;
        end else if (tmr_expired_c) begin
          abort_c = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Deliberate AXI abort: drop every handshake and report the timeout.
    if (abort_c) begin
      state_d     = ST_RESP;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_code_d  = WCI_TIMEOUT;
      rsp_data_d  = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge oped_clk125) begin
    if (oped_reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_code_q  <= '0;
      busy_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wk_q        <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_code_q  <= rsp_code_d;
      busy_q      <= busy_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wk_q        <= wk_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_code  = rsp_code_q;
  assign busy      = busy_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_awprot  = AXI_PROT_DEFAULT;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = bready_q;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = addr_q;
  assign m_arprot  = AXI_PROT_DEFAULT;
  assign m_rready  = rready_q;

endmodule

// File: tb/tb_oped_wci_axil_master.sv
// Directed bench for oped_wci_axil_master (12 workers, 1 MiB windows, TIMEOUT_CYC=16).
module tb_oped_wci_axil_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NW     = 12;
  localparam int unsigned WK_W   = 4;
  localparam int unsigned WIN    = 20;
  localparam int unsigned STRB_W = 4;

  logic              oped_clk125 = 1'b0;
  logic              oped_reset  = 1'b1;
  logic              req_valid   = 1'b0;
  logic              req_ready;
  logic              req_write   = 1'b0;
  logic [WK_W-1:0]   req_worker  = '0;
  logic [WIN-1:0]    req_offset  = '0;
  logic [DATA_W-1:0] req_wdata   = '0;
  logic [STRB_W-1:0] req_wstrb   = '0;
  logic              rsp_valid;
  logic              rsp_ready   = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_code;
  logic [NW-1:0]     fault_clr   = '0;
  logic [NW-1:0]     fault;
  logic              busy;
  logic              m_awvalid, m_awready = 1'b0;
  logic [ADDR_W-1:0] m_awaddr;
  logic [2:0]        m_awprot;
  logic              m_wvalid, m_wready = 1'b0;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_bvalid = 1'b0, m_bready;
  logic [1:0]        m_bresp  = 2'b00;
  logic              m_arvalid, m_arready = 1'b0;
  logic [ADDR_W-1:0] m_araddr;
  logic [2:0]        m_arprot;
  logic              m_rvalid = 1'b0, m_rready;
  logic [DATA_W-1:0] m_rdata  = '0;
  logic [1:0]        m_rresp  = 2'b00;

  int n_cmp = 0;
  int n_err = 0;

  oped_wci_axil_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORKERS(NW), .WIN_LOG2(WIN),
    .BASE_ADDR(32'h0), .TIMEOUT_CYC(16)
  ) dut (
    .oped_clk125(oped_clk125), .oped_reset(oped_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_worker(req_worker), .req_offset(req_offset), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_code(rsp_code), .fault_clr(fault_clr),
    .fault(fault), .busy(busy),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 oped_clk125 = ~oped_clk125;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge oped_clk125);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input string tag, input logic wr, input logic [WK_W-1:0] wk,
                          input logic [WIN-1:0] off, input logic [DATA_W-1:0] wd,
                          input logic [STRB_W-1:0] ws);
    chk({tag, "_req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_worker = wk;
    req_offset = off; req_wdata = wd; req_wstrb = ws;
    step();
    req_valid = 1'b0;
    chk({tag, "_accepted"}, {busy, req_ready}, 2'b10);
  endtask

  task automatic finish_rsp(input string tag, input logic [1:0] code,
                            input logic [DATA_W-1:0] data, input int hold);
    int bad;
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) step();
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_code"}, rsp_code, code);
    chk({tag, "_rsp_data"}, rsp_data, data);
    chk({tag, "_rsp_req_ready"}, req_ready, 0);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_code !== code || rsp_data !== data || req_ready !== 1'b0)
        bad++;
    end
    chk({tag, "_rsp_hold_stable"}, 64'(bad), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_back_idle"}, {rsp_valid, busy, req_ready}, 3'b001);
  endtask

  task automatic do_write(input string tag, input logic [WK_W-1:0] wk, input logic [WIN-1:0] off,
                          input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] ws,
                          input logic [ADDR_W-1:0] exp_addr, input int aw_lead,
                          input logic [1:0] bresp, input logic [1:0] exp_code);
    int bad;
    send_req(tag, 1'b1, wk, off, wd, ws);
    chk({tag, "_aw_w_valid"}, {m_awvalid, m_wvalid, m_arvalid}, 3'b110);
    chk({tag, "_awaddr"}, m_awaddr, exp_addr);
    chk({tag, "_wdata_wstrb"}, {m_wdata, m_wstrb}, {wd, ws});
    chk({tag, "_awprot"}, m_awprot, 0);
    bad = 0;
    if (aw_lead == 0) begin
      m_awready = 1'b1; m_wready = 1'b1;
      step();
      m_awready = 1'b0; m_wready = 1'b0;
    end else begin
      m_awready = 1'b1;
      step();
      m_awready = 1'b0;
      chk({tag, "_aw_dropped_w_held"}, {m_awvalid, m_wvalid, m_bready}, 3'b010);
      for (int i = 0; i < aw_lead - 1; i++) begin
        step();
        if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1) bad++;
      end
      m_wready = 1'b1;
      step();
      m_wready = 1'b0;
    end
    chk({tag, "_w_wait_stable"}, 64'(bad), 0);
    chk({tag, "_in_wresp"}, {m_awvalid, m_wvalid, m_bready}, 3'b001);
    m_bvalid = 1'b1; m_bresp = bresp;
    step();
    m_bvalid = 1'b0; m_bresp = 2'b00;
    chk({tag, "_bready_dropped"}, m_bready, 0);
    finish_rsp(tag, exp_code, '0, 0);
  endtask

  task automatic do_read(input string tag, input logic [WK_W-1:0] wk, input logic [WIN-1:0] off,
                         input logic [ADDR_W-1:0] exp_addr, input int ar_delay,
                         input logic [DATA_W-1:0] rdata, input logic [1:0] rresp,
                         input logic [1:0] exp_code, input logic [DATA_W-1:0] exp_data,
                         input int hold);
    int bad;
    send_req(tag, 1'b0, wk, off, '0, '0);
    chk({tag, "_arvalid"}, {m_awvalid, m_wvalid, m_arvalid}, 3'b001);
    chk({tag, "_araddr"}, m_araddr, exp_addr);
    chk({tag, "_arprot"}, m_arprot, 0);
    bad = 0;
    for (int i = 0; i < ar_delay; i++) begin
      step();
      if (m_arvalid !== 1'b1 || m_rready !== 1'b0) bad++;
    end
    chk({tag, "_ar_stall_stable"}, 64'(bad), 0);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    chk({tag, "_in_rresp"}, {m_arvalid, m_rready}, 2'b01);
    m_rvalid = 1'b1; m_rdata = rdata; m_rresp = rresp;
    step();
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    chk({tag, "_rready_dropped"}, m_rready, 0);
    finish_rsp(tag, exp_code, exp_data, hold);
  endtask

  initial begin
    int n;
    repeat (3) step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_axi", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    chk("rst_rsp", {rsp_valid, rsp_code, rsp_data}, 0);
    chk("rst_busy_fault", {busy, fault}, 0);
    oped_reset = 1'b0;
    step();
    chk("post_rst_req_ready", req_ready, 1);

    do_write("t1_wr_w3", 4'd3, 20'h00010, 32'hDEADBEEF, 4'hF, 32'h0030_0010, 0, 2'b00, 2'd0);
    do_read("t2_rd_w1", 4'd1, 20'h00004, 32'h0010_0004, 5, 32'h12345678, 2'b00, 2'd0, 32'h12345678, 0);
    do_read("t2_slverr", 4'd5, 20'h00100, 32'h0050_0100, 0, 32'hCAFEF00D, 2'b10, 2'd1, 32'h0, 0);
    do_write("t3_aw_lead", 4'd2, 20'h00008, 32'hA5A50F0F, 4'h3, 32'h0020_0008, 3, 2'b11, 2'd2);
    do_read("t_last_wk", 4'd11, 20'hFFFFC, 32'h00BF_FFFC, 1, 32'h600DF00D, 2'b00, 2'd0, 32'h600DF00D, 0);

    send_req("t6_w13", 1'b1, 4'd13, 20'h0, 32'h1, 4'hF);
    chk("t6_w13_no_axi", {m_awvalid, m_wvalid, m_arvalid}, 0);
    finish_rsp("t6_w13", 2'd2, '0, 0);
    send_req("t6_w12", 1'b0, 4'd12, 20'h0, '0, '0);
    chk("t6_w12_no_axi", {m_awvalid, m_wvalid, m_arvalid}, 0);
    finish_rsp("t6_w12", 2'd2, '0, 0);

    do_read("t5_hold", 4'd4, 20'h00040, 32'h0040_0040, 0, 32'h0BADF00D, 2'b00, 2'd0, 32'h0BADF00D, 10);

    send_req("t5_rst", 1'b1, 4'd0, 20'h00020, 32'h11112222, 4'hF);
    m_awready = 1'b1; m_wready = 1'b1;
    step();
    m_awready = 1'b0; m_wready = 1'b0;
    chk("t5_rst_in_wresp", m_bready, 1);
    oped_reset = 1'b1;
    step();
    chk("t5_rst_axi", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    chk("t5_rst_rsp", {rsp_valid, rsp_code, rsp_data}, 0);
    chk("t5_rst_ctl", {req_ready, busy, fault}, 0);
    oped_reset = 1'b0;
    step();
    step();
    chk("t5_rst_no_rsp", {rsp_valid, req_ready, busy}, 3'b010);

`ifdef OPED_WCI_TIMEOUT_EN
    send_req("t4_to", 1'b0, 4'd7, 20'h0, '0, '0);
    n = 0;
    for (int i = 0; i < 100 && rsp_valid !== 1'b1; i++) begin
      if (m_arvalid === 1'b1) n++;
      step();
    end
    chk("t4_to_arvalid_cycles", 64'(n), 16);
    chk("t4_to_dropped", {m_arvalid, m_rready}, 0);
    chk("t4_to_fault", fault, 12'h080);
    finish_rsp("t4_to", 2'd3, '0, 0);
    send_req("t4_isolated", 1'b0, 4'd7, 20'h0, '0, '0);
    chk("t4_isolated_no_ar", m_arvalid, 0);
    finish_rsp("t4_isolated", 2'd3, '0, 0);
    fault_clr = 12'h080;
    step();
    fault_clr = '0;
    chk("t4_fault_cleared", fault, 0);
    do_read("t4_recovered", 4'd7, 20'h00008, 32'h0070_0008, 2, 32'h5A5A1234, 2'b00, 2'd0, 32'h5A5A1234, 0);
`else
    n = 0;
    send_req("t4_no_to", 1'b0, 4'd7, 20'h0, '0, '0);
    for (int i = 0; i < 40; i++) begin
      if (m_arvalid !== 1'b1 || rsp_valid !== 1'b0) n++;
      step();
    end
    chk("t4_no_to_waits", 64'(n), 0);
    chk("t4_no_to_fault", fault, 0);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h5A5A1234;
    step();
    m_rvalid = 1'b0; m_rdata = '0;
    finish_rsp("t4_no_to", 2'd0, 32'h5A5A1234, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
